neighbor_req_gen: RTL and testbench

Upstream request generator for the neighbour-ID SRAM stage. It accepts one neighbour-list descriptor (bank, start row, neighbour count) from each Edge PE and arbitrates among them round-robin. It splits the granted list into per-row read requests, each in `Neighbor_info2Neighbor_FIFO` format, and writes them into the neighbour FIFO while respecting its `wfull` back-pressure. The tag on each request routes the returned neighbour IDs back to the originating Edge PE.

---
 rtl/neighbor_req_gen.sv | 198 +++++++++++++++++++
 tb/tb_neighbor_req_gen.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/neighbor_req_gen.sv
// Round-robin neighbour-list request generator feeding the neighbour-ID FIFO.
// Optional NEIGHBOR_REQ_STATS_EN adds saturating issued/stall counters.
`ifndef Num_Edge_PE
`define Num_Edge_PE 4
`endif

module neighbor_req_gen #(
    parameter int unsigned NUM_PE      = `Num_Edge_PE,
    parameter int unsigned BANK_W      = 2,
    parameter int unsigned ROW_W       = 10,
    parameter int unsigned LEN_W       = 5,
    parameter int unsigned NBR_PER_ROW = 16,
    parameter int unsigned CNT_W       = 9,
    localparam int unsigned TAG_W      = (NUM_PE > 1) ? $clog2(NUM_PE) : 1,
    // wdata layout, MSB first: {valid, bank, row, len, PE_tag}
    localparam int unsigned WDATA_W    = 1 + BANK_W + ROW_W + LEN_W + TAG_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_PE-1:0]         req_valid,
    output logic [NUM_PE-1:0]         req_ready,
    input  logic [NUM_PE*BANK_W-1:0]  req_bank,
    input  logic [NUM_PE*ROW_W-1:0]   req_row,
    input  logic [NUM_PE*CNT_W-1:0]   req_cnt,
    input  logic                      wfull,
    output logic [WDATA_W-1:0]        wdata,
    output logic [NUM_PE-1:0]         done,
`ifdef NEIGHBOR_REQ_STATS_EN
    output logic [15:0]               issued_cnt,
    output logic [15:0]               stall_cnt,
    output logic                      busy
`else
    output logic                      busy
`endif
);

    localparam int unsigned BR_W = BANK_W + ROW_W;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [TAG_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]      rem_q, rem_d;
    logic [BANK_W-1:0]     cur_bank_q, cur_bank_d;
    logic [ROW_W-1:0]      cur_row_q, cur_row_d;
    logic [TAG_W-1:0]      cur_tag_q, cur_tag_d;
    logic [NUM_PE-1:0]     done_zero_q, done_zero_d;

    logic                  grant_found;
    logic [TAG_W-1:0]      grant_idx;
    logic [TAG_W-1:0]      scan_idx;
    logic [BANK_W-1:0]     grant_bank;
    logic [ROW_W-1:0]      grant_row;
    logic [CNT_W-1:0]      grant_cnt;
    logic [CNT_W-1:0]      len_full;
    logic [LEN_W-1:0]      len_field;
    logic                  wr_en;
    logic                  last_wr;

    // Round-robin scan starting at rr_ptr, then mux out the winner's descriptor.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int i = 0; i < int'(NUM_PE); i++) begin
            scan_idx = TAG_W'((int'(rr_ptr_q) + i) % int'(NUM_PE));
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
        grant_bank = '0;
        grant_row  = '0;
        grant_cnt  = '0;
        for (int p = 0; p < int'(NUM_PE); p++) begin
            if (TAG_W'(p) == grant_idx) begin
                grant_bank = req_bank[p*BANK_W +: BANK_W];
                grant_row  = req_row[p*ROW_W +: ROW_W];
                grant_cnt  = req_cnt[p*CNT_W +: CNT_W];
            end
        end
    end

    always_comb begin
        len_full  = (rem_q > CNT_W'(NBR_PER_ROW)) ? CNT_W'(NBR_PER_ROW) : rem_q;
        len_field = len_full[LEN_W-1:0];
        wr_en     = (state_q == ISSUE) && !wfull;
        last_wr   = wr_en && (rem_q == len_full);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            rem_q       <= '0;
            cur_bank_q  <= '0;
            cur_row_q   <= '0;
            cur_tag_q   <= '0;
            done_zero_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            rem_q       <= rem_d;
            cur_bank_q  <= cur_bank_d;
            cur_row_q   <= cur_row_d;
            cur_tag_q   <= cur_tag_d;
            done_zero_q <= done_zero_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        rem_d       = rem_q;
        cur_bank_d  = cur_bank_q;
        cur_row_d   = cur_row_q;
        cur_tag_d   = cur_tag_q;
        done_zero_d = '0;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    cur_bank_d = grant_bank;
                    cur_row_d  = grant_row;
                    rem_d      = grant_cnt;
                    cur_tag_d  = grant_idx;
                    rr_ptr_d   = TAG_W'((int'(grant_idx) + 1) % int'(NUM_PE));
                    // An empty list completes without touching the FIFO.
                    if (grant_cnt == '0) begin
                        done_zero_d[grant_idx] = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (wr_en) begin
                    rem_d = rem_q - len_full;
                    // Row overflow carries into the bank field.
                    {cur_bank_d, cur_row_d} = {cur_bank_q, cur_row_q} + BR_W'(1);
                    if (last_wr) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        wdata     = '0;
        done      = done_zero_q;
        busy      = (state_q != IDLE);
        if (state_q == IDLE && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
        if (state_q == ISSUE) begin
            wdata = {!wfull, cur_bank_q, cur_row_q, len_field, cur_tag_q};
        end
        if (last_wr) begin
            done[cur_tag_q] = 1'b1;
        end
    end

`ifdef NEIGHBOR_REQ_STATS_EN
    logic [15:0] issued_cnt_q, issued_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating activity counters.
    always_comb begin
        issued_cnt_d = issued_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        if (wr_en && issued_cnt_q != 16'hFFFF) begin
            issued_cnt_d = issued_cnt_q + 16'd1;
        end
        if (state_q == ISSUE && wfull && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issued_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            issued_cnt_q <= issued_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign issued_cnt = issued_cnt_q;
    assign stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_neighbor_req_gen.sv
// Directed self-checking bench for neighbor_req_gen at default parameters.
`timescale 1ns/1ps

module tb_neighbor_req_gen;

    localparam int NUM_PE = 4;
    localparam int BANK_W = 2;
    localparam int ROW_W  = 10;
    localparam int CNT_W  = 9;
    localparam int WD_W   = 20;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_PE-1:0]         req_valid;
    logic [NUM_PE-1:0]         req_ready;
    logic [NUM_PE*BANK_W-1:0]  req_bank;
    logic [NUM_PE*ROW_W-1:0]   req_row;
    logic [NUM_PE*CNT_W-1:0]   req_cnt;
    logic                      wfull;
    logic [WD_W-1:0]           wdata;
    logic [NUM_PE-1:0]         done;
    logic                      busy;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    neighbor_req_gen dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_bank  (req_bank),
        .req_row   (req_row),
        .req_cnt   (req_cnt),
        .wfull     (wfull),
        .wdata     (wdata),
        .done      (done),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [WD_W-1:0] wexp(input int v, input int b, input int r,
                                             input int l, input int t);
        return {1'(v), 2'(b), 10'(r), 5'(l), 2'(t)};
    endfunction

    function automatic logic [31:0] onehot(input int pe);
        return 32'(1) << pe;
    endfunction

    task automatic load(input int pe, input int b, input int r, input int c);
        req_bank[pe*BANK_W +: BANK_W] = 2'(b);
        req_row[pe*ROW_W +: ROW_W]    = 10'(r);
        req_cnt[pe*CNT_W +: CNT_W]    = 9'(c);
        req_valid[pe]                 = 1'b1;
    endtask

    // Starts at a negedge with the descriptor presented; ends at the next negedge.
    task automatic accept(input int pe);
        #1;
        check("req_ready_grant", 32'(req_ready), onehot(pe));
        @(negedge clk);
        req_valid[pe] = 1'b0;
    endtask

    // Walks the expected write sequence for one list, then confirms return to IDLE.
    task automatic drain(input int pe, input int b, input int r, input int c);
        int rem;
        int len;
        logic [11:0] br;
        rem = c;
        br  = {2'(b), 10'(r)};
        if (c == 0) begin
            #1;
            check("zero_wdata", 32'(wdata), 32'(0));
            check("zero_done", 32'(done), onehot(pe));
            @(negedge clk);
        end
        while (rem > 0) begin
            len = (rem > 16) ? 16 : rem;
            #1;
            check("wdata", 32'(wdata), 32'(wexp(1, int'(br[11:10]), int'(br[9:0]), len, pe)));
            check("done", 32'(done), (rem == len) ? onehot(pe) : 32'(0));
            check("ready_in_issue", 32'(req_ready), 32'(0));
            rem -= len;
            br  = br + 12'd1;
            @(negedge clk);
        end
        #1;
        check("idle_busy", 32'(busy), 32'(0));
        check("idle_done", 32'(done), 32'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        req_valid = '0;
        req_bank  = '0;
        req_row   = '0;
        req_cnt   = '0;
        wfull     = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_wdata", 32'(wdata), 32'(0));
        check("rst_ready", 32'(req_ready), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        reset = 1'b1;
        @(negedge clk);

        // Single short list.
        load(0, 0, 0, 5);
        accept(0);
        drain(0, 0, 0, 5);

        // Multi-row split with 3 stalled cycles after the first write.
        @(negedge clk);
        load(1, 1, 2, 37);
        accept(1);
        #1;
        check("bp_first", 32'(wdata), 32'(wexp(1, 1, 2, 16, 1)));
        check("bp_busy", 32'(busy), 32'(1));
        @(negedge clk);
        wfull = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_stall_wdata", 32'(wdata), 32'(wexp(0, 1, 3, 16, 1)));
            check("bp_stall_done", 32'(done), 32'(0));
            @(negedge clk);
        end
        wfull = 1'b0;
        drain(1, 1, 3, 21);

        // Row wrap carries into bank.
        @(negedge clk);
        load(2, 0, 1023, 20);
        accept(2);
        drain(2, 0, 1023, 20);

        // Empty list on PE3.
        @(negedge clk);
        load(3, 0, 55, 0);
        accept(3);
        drain(3, 0, 55, 0);

        // All PEs pending with rr_ptr back at 0; PE0 re-requests during PE1's list.
        @(negedge clk);
        load(0, 0, 10, 3);
        load(1, 1, 20, 17);
        load(2, 2, 30, 1);
        load(3, 3, 40, 16);
        accept(0);
        drain(0, 0, 10, 3);
        accept(1);
        load(0, 3, 500, 33);
        drain(1, 1, 20, 17);
        accept(2);
        drain(2, 2, 30, 1);
        accept(3);
        drain(3, 3, 40, 16);
        accept(0);
        drain(0, 3, 500, 33);

        // Asynchronous reset in the middle of a burst.
        @(negedge clk);
        load(1, 0, 100, 48);
        accept(1);
        #1;
        check("rst_mid_first", 32'(wdata), 32'(wexp(1, 0, 100, 16, 1)));
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid_wdata", 32'(wdata), 32'(0));
        check("rst_mid_done", 32'(done), 32'(0));
        check("rst_mid_busy", 32'(busy), 32'(0));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("post_rst_busy", 32'(busy), 32'(0));
        check("post_rst_done", 32'(done), 32'(0));
        @(negedge clk);
        load(2, 3, 7, 5);
        accept(2);
        drain(2, 3, 7, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
